// File: rtl/lcd_char_render_pkg.sv
`default_nettype none
// ============================================================================
// Package   : lcd_char_pkg
// Purpose   : Shared types and constants for the LCD character renderer:
//             FSM state encoding, glyph range, font geometry, RGB565 colours
//             and the font row generator used by the font ROM.
// Revision  : 1.0 - initial release
// ============================================================================
package lcd_char_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int ASCII_OFFSET = 32;
  localparam int MAX_GLYPH    = 94;

  // Small font is 6x12, large font is 8x16
  localparam int FONT_S_W = 6;
  localparam int FONT_S_H = 12;
  localparam int FONT_L_W = 8;
  localparam int FONT_L_H = 16;

  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_BLACK = 16'h0000;

  // Font image generator. Both fonts are described arithmetically so the
  // ROM has a compact, fully deterministic image. The 6-wide font only
  // uses bits [7:2]; rows past the small-font height read as blank.
  function automatic logic [7:0] font_row_pattern(input logic       size,
                                                  input logic [6:0] glyph,
                                                  input logic [3:0] row);
    logic [7:0] w_row;
    w_row = ({1'b0, glyph} * 8'd7) + ({4'b0000, row} * 8'd29) + (size ? 8'd3 : 8'd0);
    w_row = w_row ^ 8'hA5;
    if (!size) begin
      w_row = w_row & 8'hFC;
      if (row >= 4'd12) begin
        w_row = 8'h00;
      end
    end
    return w_row;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_char_render_if.sv
`default_nettype none
// ============================================================================
// Interface : lcd_char_render_if
// Purpose   : Glyph request handshake (controller -> renderer) and pixel
//             write stream (renderer -> LCD write engine).
//             master = controller/LCD environment, slave = renderer.
// Revision  : 1.0 - initial release
// ============================================================================
interface lcd_char_render_if;
  logic        show_char_flag;
  logic [6:0]  ascii_num;
  logic [8:0]  start_x;
  logic [8:0]  start_y;
  logic        en_size;
  logic        busy;
  logic        show_char_done;
  logic        pix_valid;
  logic        pix_ready;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_color;

  modport master (
    output show_char_flag, ascii_num, start_x, start_y, en_size, pix_ready,
    input  busy, show_char_done, pix_valid, pix_x, pix_y, pix_color
  );

  modport slave (
    input  show_char_flag, ascii_num, start_x, start_y, en_size, pix_ready,
    output busy, show_char_done, pix_valid, pix_x, pix_y, pix_color
  );
endinterface
`default_nettype wire

// File: rtl/lcd_char_render_font_rom.sv
`default_nettype none
// ============================================================================
// Module    : lcd_font_rom
// Purpose   : Font ROM holding the 6x12 and 8x16 fonts. Address is
//             {size, glyph[6:0], row[3:0]}; synchronous read, one cycle
//             latency, 8-bit row word (MSB = leftmost pixel).
// Revision  : 1.0 - initial release
// ============================================================================
module lcd_font_rom
  import lcd_char_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_addr,
  output logic [7:0]  o_data
);

  logic [7:0] r_data;

  // Registered read of the addressed font row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= 8'h00;
    end else begin
      r_data <= font_row_pattern(i_addr[11], i_addr[10:4], i_addr[3:0]);
    end
  end

  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/lcd_char_render.sv
`default_nettype none
// ============================================================================
// Module    : lcd_char_render
// Purpose   : Renders one glyph per request: fetches each font row from the
//             font ROM and streams one pixel write per glyph cell over a
//             valid/ready interface, clipping cells outside the panel.
//             Optional macro LCD_CHAR_TRANSPARENT_BG_EN: clear glyph bits are
//             skipped instead of written with BG_COLOR.
// Revision  : 1.0 - initial release
// ============================================================================
module lcd_char_render
  import lcd_char_pkg::*;
#(
  parameter int          LCD_W    = 240,
  parameter int          LCD_H    = 320,
  parameter logic [15:0] FG_COLOR = RGB565_WHITE,
  parameter logic [15:0] BG_COLOR = RGB565_BLACK
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  lcd_char_render_if.slave  bus
);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [6:0]  r_ascii;
  logic [8:0]  r_sx;
  logic [8:0]  r_sy;
  logic        r_size;
  logic [3:0]  r_row;
  logic [2:0]  r_col;
  logic [7:0]  r_bits;
  logic        r_busy;
  logic        r_done;

  logic        w_accept;
  logic [2:0]  w_last_col;
  logic [3:0]  w_last_row;
  logic        w_last_pix;
  logic [9:0]  w_x;
  logic [9:0]  w_y;
  logic        w_bit;
  logic        w_clip;
  logic        w_skip;
  logic        w_adv;
  logic        w_valid;
  logic [11:0] w_rom_addr;
  logic [7:0]  w_rom_data;

  lcd_font_rom u_font_rom (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .i_addr (w_rom_addr),
    .o_data (w_rom_data)
  );

  // A request is taken only when idle, and not in the cycle that reports
  // the previous glyph's completion.
  assign w_accept   = (r_state == ST_IDLE) && bus.show_char_flag && !r_done;

  assign w_last_col = r_size ? 3'(FONT_L_W - 1) : 3'(FONT_S_W - 1);
  assign w_last_row = r_size ? 4'(FONT_L_H - 1) : 4'(FONT_S_H - 1);
  assign w_last_pix = (r_col == w_last_col);

  assign w_rom_addr = {r_size, r_ascii, r_row};

  // Coordinates are summed at 10 bits so off-panel positions are detectable
  assign w_x    = {1'b0, r_sx} + {7'b0, r_col};
  assign w_y    = {1'b0, r_sy} + {6'b0, r_row};
  assign w_bit  = r_bits[3'd7 - r_col];
  assign w_clip = (w_x >= 10'(LCD_W)) || (w_y >= 10'(LCD_H));

`ifdef LCD_CHAR_TRANSPARENT_BG_EN
  assign w_skip = w_clip || !w_bit;
`else
  assign w_skip = w_clip;
`endif

  // Skipped cells advance in one cycle; written cells wait for the engine
  assign w_adv  = (r_state == ST_EMIT) && (w_skip || bus.pix_ready);

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and pixel-valid decode
  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: w_state_nxt = ST_WAIT;
      ST_WAIT:  w_state_nxt = ST_EMIT;
      ST_EMIT: begin
        w_valid = !w_skip;
        if (w_adv && w_last_pix) begin
          w_state_nxt = (r_row == w_last_row) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, row-word capture and row/column walk
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ascii <= 7'd0;
      r_sx    <= 9'd0;
      r_sy    <= 9'd0;
      r_size  <= 1'b0;
      r_row   <= 4'd0;
      r_col   <= 3'd0;
      r_bits  <= 8'h00;
    end else begin
      if (w_accept) begin
        r_ascii <= bus.ascii_num;
        r_sx    <= bus.start_x;
        r_sy    <= bus.start_y;
        r_size  <= bus.en_size;
        r_row   <= 4'd0;
        r_col   <= 3'd0;
      end
      // Out-of-range glyph indices render blank
      if (r_state == ST_WAIT) begin
        r_bits <= (r_ascii > 7'(MAX_GLYPH)) ? 8'h00 : w_rom_data;
      end
      if (w_adv) begin
        if (w_last_pix) begin
          r_col <= 3'd0;
          if (r_row != w_last_row) begin
            r_row <= r_row + 4'd1;
          end
        end else begin
          r_col <= r_col + 3'd1;
        end
      end
    end
  end

  // Busy flag and one-cycle completion pulse
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign bus.busy           = r_busy;
  assign bus.show_char_done = r_done;
  assign bus.pix_valid      = w_valid;
  assign bus.pix_x          = w_valid ? w_x[8:0] : 9'd0;
  assign bus.pix_y          = w_valid ? w_y[8:0] : 9'd0;
  assign bus.pix_color      = w_valid ? (w_bit ? FG_COLOR : BG_COLOR) : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_render.sv
`default_nettype none
// ============================================================================
// Module    : tb_lcd_char_render
// Purpose   : Self-checking bench for lcd_char_render. A reference model
//             expands each request into the expected pixel list; a monitor
//             pops and compares every accepted pixel write.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_lcd_char_render;
  import lcd_char_pkg::*;

  localparam int LIMIT = 4000;
`ifdef LCD_CHAR_TRANSPARENT_BG_EN
  localparam int EXP_FIRST = -1;
`else
  localparam int EXP_FIRST = 3;
`endif

  typedef struct {
    int          x;
    int          y;
    logic [15:0] c;
  } pix_t;

  logic clk;
  logic rst;
  logic bp_en;
  int   n_cmp;
  int   n_bad;
  int   wr_cnt;
  int   done_cnt;
  pix_t exp_q[$];

  lcd_char_render_if bus();

  lcd_char_render dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Font image as documented for the ROM: row word of glyph g, row r
  function automatic int font_row(input bit s, input int g, input int r);
    int w;
    w = ((g * 7 + r * 29 + (s ? 3 : 0)) % 256) ^ 'hA5;
    if (!s) w = w & 'hFC;
    return w;
  endfunction

  // Reference model: expected pixel writes of one glyph, in raster order
  task automatic push_model(input int g, input int sx, input int sy, input bit s);
    int W, H, bits, x, y;
    bit b;
    pix_t p;
    W = s ? 8 : 6;
    H = s ? 16 : 12;
    for (int r = 0; r < H; r++) begin
      bits = (g > 94) ? 0 : font_row(s, g, r);
      for (int c = 0; c < W; c++) begin
        x = sx + c;
        y = sy + r;
        b = bits[7 - c];
        if (x >= 240 || y >= 320) continue;
`ifdef LCD_CHAR_TRANSPARENT_BG_EN
        if (!b) continue;
`endif
        p.x = x;
        p.y = y;
        p.c = b ? 16'hFFFF : 16'h0000;
        exp_q.push_back(p);
      end
    end
  endtask

  // Backpressure driver
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.pix_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pixel scoreboard, hold-stability and done counting
  initial begin
    bit          hold;
    logic [8:0]  hx, hy;
    logic [15:0] hc;
    pix_t        e;
    hold = 0;
    hx = '0; hy = '0; hc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0;
      end else begin
        if (hold) begin
          chk("hold_valid", 32'(bus.pix_valid), 32'd1);
          chk("hold_x", 32'(bus.pix_x), 32'(hx));
          chk("hold_y", 32'(bus.pix_y), 32'(hy));
          chk("hold_color", 32'(bus.pix_color), 32'(hc));
        end
        if (bus.pix_valid && bus.pix_ready) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_pixel: got x=%0d y=%0d expected none", bus.pix_x, bus.pix_y);
          end else begin
            e = exp_q.pop_front();
            chk("pix_x", 32'(bus.pix_x), 32'(e.x));
            chk("pix_y", 32'(bus.pix_y), 32'(e.y));
            chk("pix_color", 32'(bus.pix_color), 32'(e.c));
          end
        end
        hold = bus.pix_valid && !bus.pix_ready;
        hx = bus.pix_x;
        hy = bus.pix_y;
        hc = bus.pix_color;
        if (bus.show_char_done) done_cnt++;
      end
    end
  end

  task automatic drive_req(input int g, input int sx, input int sy, input bit s);
    bus.ascii_num      = 7'(g);
    bus.start_x        = 9'(sx);
    bus.start_y        = 9'(sy);
    bus.en_size        = s;
    bus.show_char_flag = 1'b1;
  endtask

  // One full glyph: model, request, bounded wait for done, end checks
  task automatic run_glyph(input int g, input int sx, input int sy, input bit s,
                           input bit bp, input int exp_done, input int exp_first,
                           input bit poke_busy);
    int cyc, first, n_exp, d0;
    exp_q.delete();
    push_model(g, sx, sy, s);
    n_exp  = exp_q.size();
    wr_cnt = 0;
    d0     = done_cnt;
    bp_en  = bp;
    drive_req(g, sx, sy, s);
    @(posedge clk);
    #1;
    bus.show_char_flag = 1'b0;
    cyc   = 1;
    first = -1;
    while (!bus.show_char_done && cyc < LIMIT) begin
      if (bus.pix_valid && first < 0) first = cyc;
      if (poke_busy && cyc == 20) drive_req(5, 0, 0, 0);
      if (cyc == 21) bus.show_char_flag = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("done_seen", 32'(bus.show_char_done), 32'd1);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    if (exp_done >= 0) chk("done_latency", 32'(cyc), 32'(exp_done));
    if (exp_first >= 0) chk("first_valid", 32'(first), 32'(exp_first));
    // A flag during the done cycle must be dropped
    drive_req(1, 10, 10, 0);
    @(posedge clk);
    #1;
    bus.show_char_flag = 1'b0;
    chk("done_pulse_width", 32'(bus.show_char_done), 32'd0);
    chk("flag_on_done_ignored", 32'(bus.busy), 32'd0);
    chk("write_count", 32'(wr_cnt), 32'(n_exp));
    chk("pixels_outstanding", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(d0 + 1));
    bp_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0, g, sx, sy;
    n_cmp = 0; n_bad = 0; wr_cnt = 0; done_cnt = 0;
    bp_en = 1'b0;
    rst = 1'b1;
    bus.show_char_flag = 1'b0;
    bus.ascii_num = '0; bus.start_x = '0; bus.start_y = '0; bus.en_size = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.show_char_done), 32'd0);
    chk("rst_valid", 32'(bus.pix_valid), 32'd0);
    chk("rst_x", 32'(bus.pix_x), 32'd0);
    chk("rst_y", 32'(bus.pix_y), 32'd0);
    chk("rst_color", 32'(bus.pix_color), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Glyph '0' in both sizes, ready held high
    run_glyph(48 - ASCII_OFFSET, 128, 32, 1'b0, 1'b0, 98, EXP_FIRST, 1'b0);
    run_glyph(48 - ASCII_OFFSET, 128, 32, 1'b1, 1'b0, 162, EXP_FIRST, 1'b1);
    // Random backpressure
    run_glyph(16, 128, 32, 1'b0, 1'b1, -1, EXP_FIRST, 1'b1);
    run_glyph(16, 128, 32, 1'b1, 1'b1, -1, EXP_FIRST, 1'b0);
    // Right-edge clipping, bottom-edge clipping, fully clipped glyph
    run_glyph(16, 236, 32, 1'b0, 1'b0, 98, EXP_FIRST, 1'b0);
    run_glyph(16, 10, 310, 1'b1, 1'b0, 162, EXP_FIRST, 1'b0);
    run_glyph(16, 300, 32, 1'b0, 1'b0, 98, -1, 1'b0);
    // Out-of-range glyph renders blank
    run_glyph(100, 40, 40, 1'b0, 1'b0, 98, EXP_FIRST, 1'b0);

    // Reset during row 5 of a glyph aborts it without a done pulse
    exp_q.delete();
    push_model(16, 128, 32, 1'b0);
    d0 = done_cnt;
    drive_req(16, 128, 32, 1'b0);
    @(posedge clk);
    #1;
    bus.show_char_flag = 1'b0;
    repeat (44) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_valid", 32'(bus.pix_valid), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    run_glyph(43 - ASCII_OFFSET, 60, 100, 1'b0, 1'b0, 98, EXP_FIRST, 1'b0);

    // Randomized requests
    for (int i = 0; i < 10; i++) begin
      g  = $urandom_range(0, 127);
      sx = (i % 2 == 0) ? $urandom_range(225, 245) : $urandom_range(0, 511);
      sy = (i % 2 == 0) ? $urandom_range(300, 318) : $urandom_range(0, 330);
      run_glyph(g, sx, sy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                -1, -1, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
